mem_access: RTL and testbench

Memory-access stage directly downstream of the execute stage. Takes the ALU result `d`, store data `t` and control bits, drives a word-addressed synchronous BRAM for loads/stores, and produces a one-cycle writeback pulse for the register file. Loads stall the upstream stage through a valid/ready handshake while the BRAM read latency elapses.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/mem_access_if.sv | 33 +++
 rtl/mem_access.sv | 119 +++++++++++
 tb/tb_mem_access.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared CPU constants and the memory-stage state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int         DATA_W   = 32;
    localparam logic [4:0] REG_LINK = 5'd31;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_if
// Purpose  : Execute -> memory-access instruction handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_if
    import cpu_pkg::*;
#(
    parameter int INST_SIZE = 10
);
    logic                 in_valid;
    logic                 in_ready;
    logic [INST_SIZE-1:0] pc;
    logic [DATA_W-1:0]    d;
    logic [DATA_W-1:0]    t;
    logic [4:0]           rd;
    logic                 rea;
    logic                 wea;
    logic                 reg_we;
    logic                 is_jal;

    modport master (
        output in_valid, pc, d, t, rd, rea, wea, reg_we, is_jal,
        input  in_ready
    );

    modport slave (
        input  in_valid, pc, d, t, rd, rea, wea, reg_we, is_jal,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : Memory-access stage: BRAM load/store and one-cycle writeback.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access
    import cpu_pkg::*;
#(
    parameter int INST_SIZE    = 10,
    parameter int BRAM_SIZE    = 18,
    parameter int LOAD_LATENCY = 2
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    mem_access_if.slave               ex,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [BRAM_SIZE-1:0]      mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  wire logic [DATA_W-1:0]    mem_rdata,
    output logic                      wb_valid,
    output logic                      wb_we,
    output logic [4:0]                wb_rd,
    output logic [DATA_W-1:0]         wb_data
);

    localparam int CNT_W = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;

    mem_state_t        r_state;
    mem_state_t        w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [4:0]        r_ld_rd;
    logic              r_ld_we;
    logic              w_accept;
    logic              w_is_load;
    logic [4:0]        w_rd;
    logic [DATA_W-1:0] w_link;

    // A store flag wins over a load flag on the same instruction.
    assign w_is_load = ex.rea && !ex.wea;
    assign w_rd      = ex.is_jal ? REG_LINK : ex.rd;
    assign w_link    = {{(DATA_W-INST_SIZE){1'b0}}, ex.pc} + DATA_W'(1);
    assign mem_addr  = ex.d[BRAM_SIZE+1:2];
    assign mem_wdata = ex.t;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ex.in_ready  = 1'b0;
        w_accept     = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        if (!rst) begin
            ex.in_ready = (r_state == IDLE);
            w_accept    = ex.in_ready && ex.in_valid;
            mem_en      = w_accept && (ex.rea || ex.wea);
            mem_we      = w_accept && ex.wea;
        end
        case (r_state)
            IDLE: begin
                if (w_accept && w_is_load) begin
                    w_state_next = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_ld_rd  <= REG_ZERO;
            r_ld_we  <= 1'b0;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= REG_ZERO;
            wb_data  <= '0;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            if (w_accept) begin
                if (w_is_load) begin
                    r_cnt   <= CNT_W'(LOAD_LATENCY - 1);
                    r_ld_rd <= ex.rd;
                    r_ld_we <= ex.reg_we;
                end else begin
                    wb_valid <= 1'b1;
                    wb_rd    <= w_rd;
                    wb_data  <= ex.is_jal ? w_link : ex.d;
                    wb_we    <= (ex.reg_we || ex.is_jal) && !ex.wea && (w_rd != REG_ZERO);
                end
            end else if (r_state == LOAD_WAIT) begin
                if (r_cnt == '0) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= r_ld_rd;
                    wb_data  <= mem_rdata;
                    wb_we    <= r_ld_we && (r_ld_rd != REG_ZERO);
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Self-checking bench for mem_access against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access;
    import cpu_pkg::*;

    localparam int LL = 2;

    logic        clk;
    logic        rst;
    logic        mem_en, mem_we;
    logic [17:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_if #(.INST_SIZE(10)) ex ();

    mem_access #(
        .INST_SIZE    (10),
        .BRAM_SIZE    (18),
        .LOAD_LATENCY (LL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ex        (ex),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .wb_valid  (wb_valid),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(input logic [17:0] a);
        return {a[13:0], a} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // BRAM with LL-cycle read latency
    logic [31:0] bram [logic [17:0]];
    logic [31:0] pipe [LL];
    assign mem_rdata = pipe[LL-1];

    always @(posedge clk) begin
        if (mem_en && mem_we) bram[mem_addr] = mem_wdata;
        if (mem_en && !mem_we) pipe[0] <= bram.exists(mem_addr) ? bram[mem_addr] : dflt(mem_addr);
        for (int i = 1; i < LL; i++) pipe[i] <= pipe[i-1];
    end

    // Reference model: expected writebacks keyed by the cycle they appear in
    typedef struct {
        int          cyc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t         wbq [$];
    logic [31:0] shadow [logic [17:0]];
    int          cyc      = 0;
    int          ready_at = 0;
    bit          started  = 0;
    bit          clean    = 0;

    always @(negedge clk) begin
        logic        exp_v, exp_ready, acc, mem_op;
        logic [17:0] a;
        logic [4:0]  r;
        wb_t         e;
        if (started) begin
            exp_v = (wbq.size() > 0) && (wbq[0].cyc == cyc);
            chk("wb_valid", {31'd0, wb_valid}, {31'd0, exp_v});
            if (exp_v) begin
                e = wbq.pop_front();
                chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("wb_data", wb_data, e.data);
                clean = 0;
            end else begin
                chk("wb_we_idle", {31'd0, wb_we}, 32'd0);
                if (clean) begin
                    chk("wb_rd_rst", {27'd0, wb_rd}, 32'd0);
                    chk("wb_data_rst", wb_data, 32'd0);
                end
            end
            exp_ready = !rst && (cyc >= ready_at);
            chk("in_ready", {31'd0, ex.in_ready}, {31'd0, exp_ready});
            acc    = exp_ready && ex.in_valid;
            mem_op = acc && (ex.rea || ex.wea);
            a      = ex.d[19:2];
            chk("mem_en", {31'd0, mem_en}, {31'd0, mem_op});
            chk("mem_we", {31'd0, mem_we}, {31'd0, acc && ex.wea});
            if (mem_op) chk("mem_addr", {14'd0, mem_addr}, {14'd0, a});
            if (acc && ex.wea) begin
                chk("mem_wdata", mem_wdata, ex.t);
                shadow[a] = ex.t;
            end
            if (rst) begin
                wbq.delete();
                ready_at = 0;
                clean    = 1;
            end else if (acc) begin
                if (ex.rea && !ex.wea) begin
                    e.cyc  = cyc + LL + 1;
                    e.rd   = ex.rd;
                    e.we   = ex.reg_we && (ex.rd != 0);
                    e.data = shadow.exists(a) ? shadow[a] : dflt(a);
                    ready_at = cyc + LL + 1;
                end else begin
                    r      = ex.is_jal ? 5'd31 : ex.rd;
                    e.cyc  = cyc + 1;
                    e.rd   = r;
                    e.we   = (ex.reg_we || ex.is_jal) && !ex.wea && (r != 0);
                    e.data = ex.is_jal ? (32'(ex.pc) + 32'd1) : ex.d;
                end
                wbq.push_back(e);
            end
        end
        if (rst) started = 1;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [9:0] p, input logic [31:0] dd, input logic [31:0] tt,
                       input logic [4:0] r, input logic re, input logic we, input logic rw, input logic j);
        ex.in_valid = v;
        ex.pc       = p;
        ex.d        = dd;
        ex.t        = tt;
        ex.rd       = r;
        ex.rea      = re;
        ex.wea      = we;
        ex.reg_we   = rw;
        ex.is_jal   = j;
    endtask

    task automatic idle();
        drv(1'b0, 10'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] dd;
        int          kind;
        rst = 1'b1;
        idle();
        repeat (3) tick();
        chk("lit_rst_ready", {31'd0, ex.in_ready}, 32'd0);
        chk("lit_rst_mem_en", {31'd0, mem_en}, 32'd0);
        rst = 1'b0;
        #1;
        chk("lit_ready_after_rst", {31'd0, ex.in_ready}, 32'd1);
        chk("lit_wb_valid_after_rst", {31'd0, wb_valid}, 32'd0);
        chk("lit_wb_data_after_rst", wb_data, 32'd0);

        // Back-to-back ALU results
        tick();
        drv(1'b1, 10'd1, 32'h11, 32'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 chk("lit_alu_mem_en", {31'd0, mem_en}, 32'd0);
        tick();
        chk("lit_alu1_valid", {31'd0, wb_valid}, 32'd1);
        chk("lit_alu1_rd", {27'd0, wb_rd}, 32'd3);
        chk("lit_alu1_data", wb_data, 32'h11);
        drv(1'b1, 10'd2, 32'h22, 32'd0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("lit_alu2_valid", {31'd0, wb_valid}, 32'd1);
        chk("lit_alu2_rd", {27'd0, wb_rd}, 32'd4);
        chk("lit_alu2_data", wb_data, 32'h22);
        idle();

        // Store then load from the same word
        tick();
        drv(1'b1, 10'd3, 32'h40, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lit_st_addr", {14'd0, mem_addr}, 32'h10);
        chk("lit_st_we", {31'd0, mem_we}, 32'd1);
        tick();
        drv(1'b1, 10'd4, 32'h40, 32'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        #1 chk("lit_ld_en", {31'd0, mem_en}, 32'd1);
        tick();
        idle();
        #1 chk("lit_ld_stall1", {31'd0, ex.in_ready}, 32'd0);
        tick();
        chk("lit_ld_stall2", {31'd0, ex.in_ready}, 32'd0);
        chk("lit_ld_no_wb_yet", {31'd0, wb_valid}, 32'd0);
        tick();
        chk("lit_ld_valid", {31'd0, wb_valid}, 32'd1);
        chk("lit_ld_data", wb_data, 32'hDEADBEEF);
        chk("lit_ld_rd", {27'd0, wb_rd}, 32'd5);
        chk("lit_ld_ready", {31'd0, ex.in_ready}, 32'd1);

        // JAL link write of pc+1 into r31
        drv(1'b1, 10'h3FF, 32'h999, 32'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("lit_jal_rd", {27'd0, wb_rd}, 32'd31);
        chk("lit_jal_data", wb_data, 32'h400);
        chk("lit_jal_we", {31'd0, wb_we}, 32'd1);

        // r0 destination, then rea+wea together
        drv(1'b1, 10'd5, 32'd5, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("lit_r0_valid", {31'd0, wb_valid}, 32'd1);
        chk("lit_r0_we", {31'd0, wb_we}, 32'd0);
        drv(1'b1, 10'd6, 32'h80, 32'h1234, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 chk("lit_rw_mem_we", {31'd0, mem_we}, 32'd1);
        tick();
        chk("lit_rw_valid", {31'd0, wb_valid}, 32'd1);
        chk("lit_rw_we", {31'd0, wb_we}, 32'd0);
        chk("lit_rw_ready", {31'd0, ex.in_ready}, 32'd1);

        // Reset while a load is outstanding
        drv(1'b1, 10'd7, 32'h40, 32'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        rst = 1'b1;
        #1 chk("lit_rstld_ready", {31'd0, ex.in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1 chk("lit_rstld_ready_after", {31'd0, ex.in_ready}, 32'd1);
        repeat (3) begin
            chk("lit_rstld_no_wb", {31'd0, wb_valid}, 32'd0);
            tick();
        end

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            kind = int'($urandom_range(0, 7));
            dd   = $urandom;
            if (kind <= 3) dd[19:2] = 18'($urandom_range(0, 31));
            drv(($urandom % 4) != 0, 10'($urandom), dd, $urandom,
                (($urandom % 5) == 0) ? 5'd0 : 5'($urandom),
                (kind <= 1) || (kind == 3), (kind == 2) || (kind == 3),
                1'($urandom), kind == 4);
            rst = (($urandom % 97) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        repeat (LL + 3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
